instr_decode_exec: RTL and testbench

//  Downstream stage of instruction_mem. Latches the 9-bit instruction word, decodes it, and executes it on a 4x8 register file with an ALU.

---
 rtl/ide_pkg.sv | 42 ++++
 rtl/instr_decode_exec_if.sv | 40 ++++
 rtl/ide_regfile.sv | 36 +++
 rtl/instr_decode_exec.sv | 150 +++++++++++++++
 tb/tb_instr_decode_exec.sv | 207 ++++++++++++++++++++
 5 files changed

// File: rtl/ide_pkg.sv
// Shared definitions for instr_decode_exec: widths, opcodes, FSM state
// encodings, instruction field positions and a zero-detect helper.
// Optional feature macro used by the bundle: RETIRE_CNT_EN.
package ide_pkg;

    localparam int IW = 9;
    localparam int DW = 8;
    localparam int NR = 4;

    // Opcodes, instruction bits [7:5]
    localparam logic [2:0] OP_NOP = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_SUB = 3'b010;
    localparam logic [2:0] OP_AND = 3'b011;
    localparam logic [2:0] OP_OR  = 3'b100;
    localparam logic [2:0] OP_LDI = 3'b101;
    localparam logic [2:0] OP_MOV = 3'b110;
    localparam logic [2:0] OP_NOT = 3'b111;

    // FSM state encodings
    localparam logic [2:0] S_FETCH  = 3'd0;
    localparam logic [2:0] S_DECODE = 3'd1;
    localparam logic [2:0] S_EXEC   = 3'd2;
    localparam logic [2:0] S_ADV    = 3'd3;
    localparam logic [2:0] S_HALT   = 3'd4;

    // Instruction field bit positions (rs and imm3 overlap on purpose)
    localparam int RUN_BIT = 8;
    localparam int OP_MSB  = 7;
    localparam int OP_LSB  = 5;
    localparam int RD_MSB  = 4;
    localparam int RD_LSB  = 3;
    localparam int RS_MSB  = 2;
    localparam int RS_LSB  = 1;
    localparam int IMM_MSB = 2;
    localparam int IMM_LSB = 0;

    function automatic logic is_zero(input logic [DW-1:0] v);
        return (v == {DW{1'b0}});
    endfunction

endpackage

// File: rtl/instr_decode_exec_if.sv
// Bus between instruction_mem / program_counter / debug host and
// instr_decode_exec. retire_cnt exists only when RETIRE_CNT_EN is defined.
interface instr_decode_exec_if;
    import ide_pkg::*;

    logic [IW-1:0] instr;
    logic          pc_en;
    logic          halted;
    logic          zero;
    logic [1:0]    dbg_sel;
    logic [DW-1:0] dbg_data;
`ifdef RETIRE_CNT_EN
    logic [15:0]   retire_cnt;
`endif

    modport slave (
        input  instr,
        input  dbg_sel,
        output pc_en,
        output halted,
        output zero,
        output dbg_data
`ifdef RETIRE_CNT_EN
        , output retire_cnt
`endif
    );

    modport master (
        output instr,
        output dbg_sel,
        input  pc_en,
        input  halted,
        input  zero,
        input  dbg_data
`ifdef RETIRE_CNT_EN
        , input retire_cnt
`endif
    );

endinterface

// File: rtl/ide_regfile.sv
// NR x DW register file: three asynchronous read ports (rd, rs, debug),
// one synchronous write port, synchronous active-low clear of all entries.
module ide_regfile
    import ide_pkg::*;
(
    input  logic          clk_i,
    input  logic          clr_n_i,
    input  logic          we_i,
    input  logic [1:0]    wa_i,
    input  logic [DW-1:0] wd_i,
    input  logic [1:0]    ra_rd_i,
    input  logic [1:0]    ra_rs_i,
    input  logic [1:0]    ra_dbg_i,
    output logic [DW-1:0] rd_data_o,
    output logic [DW-1:0] rs_data_o,
    output logic [DW-1:0] dbg_data_o
);

    logic [DW-1:0] regs_q [NR];

    // Clear has priority over any write in the same cycle
    always_ff @(posedge clk_i) begin
        if (!clr_n_i) begin
            for (int i = 0; i < NR; i++) begin
                regs_q[i] <= {DW{1'b0}};
            end
        end else if (we_i) begin
            regs_q[wa_i] <= wd_i;
        end
    end

    assign rd_data_o  = regs_q[ra_rd_i];
    assign rs_data_o  = regs_q[ra_rs_i];
    assign dbg_data_o = regs_q[ra_dbg_i];

endmodule

// File: rtl/instr_decode_exec.sv
// instr_decode_exec: 4-clock, non-pipelined decode/execute stage behind
// instruction_mem. FETCH -> DECODE -> EXEC -> ADV, plus terminal HALT.
// Optional: define RETIRE_CNT_EN to add the 16-bit retire_cnt output.
module instr_decode_exec
    import ide_pkg::*;
(
    input  logic               clk,
    input  logic               res,
    instr_decode_exec_if.slave bus
);

    logic [2:0]    state_q, state_d;
    logic [IW-1:0] ir_q, ir_d;
    logic          zero_q, zero_d;
    logic          halted_q, halted_d;
    logic          pc_en_q, pc_en_d;
    logic          wr_en_s;

    logic [2:0]    op_s;
    logic [1:0]    rd_s;
    logic [1:0]    rs_s;
    logic [2:0]    imm_s;
    logic [DW-1:0] rd_val_s, rs_val_s, dbg_val_s;
    logic [DW-1:0] alu_res_s;
    logic          alu_we_s;

    assign op_s  = ir_q[OP_MSB:OP_LSB];
    assign rd_s  = ir_q[RD_MSB:RD_LSB];
    assign rs_s  = ir_q[RS_MSB:RS_LSB];
    assign imm_s = ir_q[IMM_MSB:IMM_LSB];

    ide_regfile u_regfile (
        .clk_i      (clk),
        .clr_n_i    (res),
        .we_i       (wr_en_s),
        .wa_i       (rd_s),
        .wd_i       (alu_res_s),
        .ra_rd_i    (rd_s),
        .ra_rs_i    (rs_s),
        .ra_dbg_i   (bus.dbg_sel),
        .rd_data_o  (rd_val_s),
        .rs_data_o  (rs_val_s),
        .dbg_data_o (dbg_val_s)
    );

    // ALU: result from pre-write register values; NOP writes nothing
    always_comb begin
        alu_res_s = {DW{1'b0}};
        alu_we_s  = ir_q[RUN_BIT];
        case (op_s)
            OP_NOP: begin
                alu_res_s = rd_val_s;
                alu_we_s  = 1'b0;
            end
            OP_ADD:  alu_res_s = rd_val_s + rs_val_s;
            OP_SUB:  alu_res_s = rd_val_s - rs_val_s;
            OP_AND:  alu_res_s = rd_val_s & rs_val_s;
            OP_OR:   alu_res_s = rd_val_s | rs_val_s;
            OP_LDI:  alu_res_s = {{(DW-3){1'b0}}, imm_s};
            OP_MOV:  alu_res_s = rs_val_s;
            OP_NOT:  alu_res_s = ~rd_val_s;
            default: begin
                alu_res_s = {DW{1'b0}};
                alu_we_s  = 1'b0;
            end
        endcase
    end

    // FSM next state, instruction latch, flags and retire strobe
    always_comb begin
        state_d  = state_q;
        ir_d     = ir_q;
        zero_d   = zero_q;
        halted_d = halted_q;
        pc_en_d  = 1'b0;
        wr_en_s  = 1'b0;
        case (state_q)
            S_FETCH: state_d = S_DECODE;
            S_DECODE: begin
                ir_d = bus.instr;
                if (bus.instr[RUN_BIT] == 1'b0) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else begin
                    state_d  = S_EXEC;
                end
            end
            S_EXEC: begin
                if (alu_we_s) begin
                    wr_en_s = res;
                    zero_d  = is_zero(alu_res_s);
                end else begin
                    wr_en_s = 1'b0;
                end
                pc_en_d = 1'b1;
                state_d = S_ADV;
            end
            S_ADV:   state_d = S_FETCH;
            S_HALT:  state_d = S_HALT;
            default: state_d = S_FETCH;
        endcase
    end

    // State registers with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!res) begin
            state_q  <= S_FETCH;
            ir_q     <= {IW{1'b0}};
            zero_q   <= 1'b0;
            halted_q <= 1'b0;
            pc_en_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            ir_q     <= ir_d;
            zero_q   <= zero_d;
            halted_q <= halted_d;
            pc_en_q  <= pc_en_d;
        end
    end

`ifdef RETIRE_CNT_EN
    logic [15:0] retire_cnt_q, retire_cnt_d;

    // Count retired instructions; wraps naturally at 16 bits
    always_comb begin
        if (state_q == S_ADV) begin
            retire_cnt_d = retire_cnt_q + 16'd1;
        end else begin
            retire_cnt_d = retire_cnt_q;
        end
    end

    // Retire counter register
    always_ff @(posedge clk) begin
        if (!res) begin
            retire_cnt_q <= 16'd0;
        end else begin
            retire_cnt_q <= retire_cnt_d;
        end
    end

    assign bus.retire_cnt = retire_cnt_q;
`endif

    assign bus.pc_en    = pc_en_q;
    assign bus.halted   = halted_q;
    assign bus.zero     = zero_q;
    assign bus.dbg_data = dbg_val_s;

endmodule

// File: tb/tb_instr_decode_exec.sv
// Testbench for instr_decode_exec with a registered instruction memory and
// program counter model around the DUT.
module tb_instr_decode_exec;
    import ide_pkg::*;

    logic clk = 1'b0;
    logic res;
    always #5 clk = ~clk;

    instr_decode_exec_if bus ();
    instr_decode_exec u_dut (.clk(clk), .res(res), .bus(bus.slave));

    logic [8:0] mem [0:63];
    logic [5:0] pc;
    int n_cmp = 0;
    int n_bad = 0;

    // Registered memory and PC models
    always @(posedge clk) begin
        bus.instr <= mem[pc];
        if (!res) pc <= 6'd0;
        else if (bus.pc_en) pc <= pc + 6'd1;
    end

    // pc_en must never be high two cycles running, nor while halted
    logic prev_pc_en = 1'b0;
    always @(negedge clk) begin
        if (bus.pc_en === 1'b1) begin
            n_cmp++;
            if (prev_pc_en === 1'b1 || bus.halted !== 1'b0) begin
                n_bad++;
                $display("FAIL pc_en_pulse: got back-to-back or halted pulse, required single pulse");
            end
        end
        prev_pc_en <= bus.pc_en;
    end

    typedef struct packed {
        logic [8:0] word;
        logic [1:0] sel;
        logic [7:0] val;
        logic       z;
    } vec_t;
    vec_t vecs [16];

    function automatic logic [8:0] enc(input logic [2:0] op, input logic [1:0] rd, input logic [2:0] low);
        return {1'b1, op, rd, low};
    endfunction
    function automatic logic [8:0] encr(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs);
        return {1'b1, op, rd, rs, 1'b0};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h required 0x%0h", name, act, exp);
        end
    endtask

    task automatic wait_pc_en(input int limit, output int n);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (bus.pc_en !== 1'b1 && n < limit);
        if (bus.pc_en !== 1'b1) begin
            n_cmp++;
            n_bad++;
            $display("FAIL pc_en_timeout: got no pulse in %0d clk, required one", limit);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        res = 1'b0;
        repeat (2) @(negedge clk);
        res = 1'b1;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 64; i++) mem[i] = 9'h000;
    endtask

    task automatic read_reg(input logic [1:0] sel, output logic [7:0] v);
        bus.dbg_sel = sel;
        #1;
        v = bus.dbg_data;
    endtask

    initial begin
        int n;
        int cnt;
        logic [7:0] v;
        res = 1'b0;
        bus.dbg_sel = 2'd0;

        // Run A: table of instructions, each checked at its ADV cycle
        vecs[0]  = '{enc(OP_LDI, 2'd1, 3'd5),  2'd1, 8'h05, 1'b0};
        vecs[1]  = '{enc(OP_LDI, 2'd0, 3'd3),  2'd0, 8'h03, 1'b0};
        vecs[2]  = '{enc(OP_LDI, 2'd1, 3'd3),  2'd1, 8'h03, 1'b0};
        vecs[3]  = '{encr(OP_SUB, 2'd0, 2'd1), 2'd0, 8'h00, 1'b1};
        vecs[4]  = '{enc(OP_LDI, 2'd2, 3'd0),  2'd2, 8'h00, 1'b1};
        vecs[5]  = '{encr(OP_NOT, 2'd2, 2'd0), 2'd2, 8'hFF, 1'b0};
        vecs[6]  = '{encr(OP_ADD, 2'd2, 2'd2), 2'd2, 8'hFE, 1'b0};
        vecs[7]  = '{encr(OP_AND, 2'd2, 2'd1), 2'd2, 8'h02, 1'b0};
        vecs[8]  = '{encr(OP_OR,  2'd0, 2'd1), 2'd0, 8'h03, 1'b0};
        vecs[9]  = '{encr(OP_MOV, 2'd3, 2'd2), 2'd3, 8'h02, 1'b0};
        vecs[10] = '{encr(OP_SUB, 2'd1, 2'd1), 2'd1, 8'h00, 1'b1};
        vecs[11] = '{encr(OP_NOP, 2'd3, 2'd0), 2'd3, 8'h02, 1'b1};
        vecs[12] = '{encr(OP_ADD, 2'd0, 2'd3), 2'd0, 8'h05, 1'b0};
        vecs[13] = '{encr(OP_NOP, 2'd0, 2'd0), 2'd0, 8'h05, 1'b0};
        vecs[14] = '{enc(OP_LDI, 2'd3, 3'd7),  2'd3, 8'h07, 1'b0};
        vecs[15] = '{encr(OP_SUB, 2'd1, 2'd0), 2'd1, 8'hFB, 1'b0};
        clear_mem();
        for (int i = 0; i < 16; i++) mem[i] = vecs[i].word;

        repeat (2) @(negedge clk);
        for (int r = 0; r < 4; r++) begin
            read_reg(r[1:0], v);
            check($sformatf("reset_reg%0d", r), {8'h00, v}, 16'h0000);
        end
        check("reset_pc_en", {15'd0, bus.pc_en}, 16'd0);
        check("reset_halted", {15'd0, bus.halted}, 16'd0);
        check("reset_zero", {15'd0, bus.zero}, 16'd0);
`ifdef RETIRE_CNT_EN
        check("reset_retire_cnt", bus.retire_cnt, 16'd0);
`endif
        bus.dbg_sel = 2'd0;
        res = 1'b1;

        for (int i = 0; i < 16; i++) begin
            bus.dbg_sel = vecs[i].sel;
            wait_pc_en(8, n);
            check($sformatf("vec%0d_spacing", i), n[15:0], (i == 0) ? 16'd3 : 16'd4);
            check($sformatf("vec%0d_reg", i), {8'h00, bus.dbg_data}, {8'h00, vecs[i].val});
            check($sformatf("vec%0d_zero", i), {15'd0, bus.zero}, {15'd0, vecs[i].z});
        end
        n = 0;
        while (bus.halted !== 1'b1 && n < 8) begin
            @(negedge clk);
            n++;
        end
        check("runA_halted", {15'd0, bus.halted}, 16'd1);
        check("runA_pc", {10'd0, pc}, 16'd16);
`ifdef RETIRE_CNT_EN
        check("runA_retire_cnt", bus.retire_cnt, 16'd16);
`endif

        // Run B: halt word at address 3
        clear_mem();
        mem[0] = enc(OP_LDI, 2'd0, 3'd1);
        mem[1] = enc(OP_LDI, 2'd1, 3'd2);
        mem[2] = encr(OP_ADD, 2'd0, 2'd1);
        do_reset();
        bus.dbg_sel = 2'd0;
        for (int i = 0; i < 3; i++) wait_pc_en(8, n);
        check("runB_r0", {8'h00, bus.dbg_data}, 16'h0003);
        repeat (2) @(negedge clk);
        check("runB_halted_decode", {15'd0, bus.halted}, 16'd0);
        @(negedge clk);
        check("runB_halted_set", {15'd0, bus.halted}, 16'd1);
        cnt = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (bus.pc_en !== 1'b0) cnt++;
        end
        check("runB_idle_pc_en", cnt[15:0], 16'd0);
        check("runB_pc_frozen", {10'd0, pc}, 16'd3);
        check("runB_r0_kept", {8'h00, bus.dbg_data}, 16'h0003);
        check("runB_zero_kept", {15'd0, bus.zero}, 16'd0);
        check("runB_halted_sticky", {15'd0, bus.halted}, 16'd1);

        // Run C: reset asserted during EXEC of LDI r3,7
        clear_mem();
        mem[0] = enc(OP_LDI, 2'd3, 3'd7);
        mem[1] = enc(OP_LDI, 2'd0, 3'd5);
        do_reset();
        bus.dbg_sel = 2'd3;
        repeat (2) @(negedge clk);
        res = 1'b0;
        @(negedge clk);
        check("runC_r3_dropped", {8'h00, bus.dbg_data}, 16'h0000);
        check("runC_pc_en", {15'd0, bus.pc_en}, 16'd0);
        check("runC_halted", {15'd0, bus.halted}, 16'd0);
        res = 1'b1;
        wait_pc_en(8, n);
        check("runC_restart_latency", n[15:0], 16'd3);
        check("runC_r3", {8'h00, bus.dbg_data}, 16'h0007);
        bus.dbg_sel = 2'd0;
        wait_pc_en(8, n);
        check("runC_second_spacing", n[15:0], 16'd4);
        check("runC_r0", {8'h00, bus.dbg_data}, 16'h0005);

        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Absolute time limit
    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

endmodule
